multicycle_control: RTL and testbench

- Multi-cycle sequencer for the RV32I core. Replaces the single-cycle control path so that one ALU and one unified instruction/data memory serve each instruction across several cycles.
- Decodes op/funct fields once per instruction. Drives register-file, ALU, memory and PC enables and mux selects state by state.
- Handshakes with the memory port, runs a watchdog on memory waits, and traps on illegal opcodes.

---
 rtl/rv_ctrl_pkg.sv | 76 +++++++
 rtl/alu_op_decoder.sv | 30 +++
 rtl/multicycle_control.sv | 200 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the RV32I multi-cycle control path.
// Covers FSM states, opcodes, ALU controls and datapath mux selects.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StJal,
    StBeq,
    StTrap
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluAnd = 3'b010,
    AluOr  = 3'b011,
    AluSlt = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10
  } alu_op_e;

  localparam logic       AdrPc     = 1'b0;
  localparam logic       AdrAluOut = 1'b1;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;

  localparam logic [1:0] SrcBRs2   = 2'b00;
  localparam logic [1:0] SrcBImm   = 2'b01;
  localparam logic [1:0] SrcBFour  = 2'b10;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResMemData   = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;
  localparam logic [1:0] ImmJ = 2'b11;

  localparam logic TrapIllegal = 1'b0;
  localparam logic TrapTimeout = 1'b1;

  // Immediate format depends only on the opcode, so it is valid in every state.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    logic [1:0] imm;
    case (op)
      OpStore:  imm = ImmS;
      OpBranch: imm = ImmB;
      OpJal:    imm = ImmJ;
      default:  imm = ImmI;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Maps the coarse alu_op from the sequencer plus funct fields to an ALU operation.
module alu_op_decoder
  import rv_ctrl_pkg::*;
(
  input  alu_op_e     alu_op_i,
  input  logic        op5_i,
  input  logic [2:0]  funct3_i,
  input  logic        funct7b5_i,
  output alu_ctrl_e   alu_ctrl_o
);

  always_comb begin
    alu_ctrl_o = AluAdd;
    case (alu_op_i)
      AluOpSub: alu_ctrl_o = AluSub;
      AluOpFunct: begin
        case (funct3_i)
          // funct7b5 selects sub only for register-register ops; addi ignores it
          3'b000:  alu_ctrl_o = (op5_i && funct7b5_i) ? AluSub : AluAdd;
          3'b010:  alu_ctrl_o = AluSlt;
          3'b110:  alu_ctrl_o = AluOr;
          3'b111:  alu_ctrl_o = AluAnd;
          default: alu_ctrl_o = AluAdd;
        endcase
      end
      default: alu_ctrl_o = AluAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencer: Moore FSM driving datapath enables and selects,
// with a memory-wait watchdog and a sticky trap on illegal opcodes or timeouts.
module multicycle_control
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic [2:0] alu_ctrl,
  output logic       trap,
  output logic       trap_cause
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trap_q, trap_cause_q;

  logic      mem_req_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c;
  logic      wait_st, timeout, cause_c;
  alu_op_e   alu_op;
  alu_ctrl_e alu_ctrl_w;

  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    state_d     = state_q;
    cause_c     = TrapIllegal;
    wait_st     = 1'b0;
    mem_req_c   = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    adr_src     = AdrPc;
    alu_src_a   = SrcAPc;
    alu_src_b   = SrcBRs2;
    result_src  = ResAluOut;
    alu_op      = AluOpAdd;

    unique case (state_q)
      StFetch: begin
        wait_st    = 1'b1;
        mem_req_c  = 1'b1;
        alu_src_b  = SrcBFour;
        result_src = ResAluResult;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = StDecode;
        end else if (timeout) begin
          cause_c = TrapTimeout;
          state_d = StTrap;
        end
      end
      StDecode: begin
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBImm;
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecR;
          OpIType:         state_d = StExecI;
          OpBranch:        state_d = StBeq;
          OpJal:           state_d = StJal;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr: begin
        alu_src_a = SrcARs1;
        alu_src_b = SrcBImm;
        state_d   = op[5] ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        wait_st   = 1'b1;
        mem_req_c = 1'b1;
        adr_src   = AdrAluOut;
        if (mem_ready) begin
          state_d = StMemWb;
        end else if (timeout) begin
          cause_c = TrapTimeout;
          state_d = StTrap;
        end
      end
      StMemWb: begin
        result_src  = ResMemData;
        reg_write_c = 1'b1;
        state_d     = StFetch;
      end
      StMemWrite: begin
        wait_st     = 1'b1;
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        adr_src     = AdrAluOut;
        if (mem_ready) begin
          state_d = StFetch;
        end else if (timeout) begin
          cause_c = TrapTimeout;
          state_d = StTrap;
        end
      end
      StExecR: begin
        alu_src_a = SrcARs1;
        alu_src_b = SrcBRs2;
        alu_op    = AluOpFunct;
        state_d   = StAluWb;
      end
      StExecI: begin
        alu_src_a = SrcARs1;
        alu_src_b = SrcBImm;
        alu_op    = AluOpFunct;
        state_d   = StAluWb;
      end
      StAluWb: begin
        result_src  = ResAluOut;
        reg_write_c = 1'b1;
        state_d     = StFetch;
      end
      StJal: begin
        alu_src_a  = SrcAOldPc;
        alu_src_b  = SrcBFour;
        result_src = ResAluOut;
        pc_write_c = 1'b1;
        state_d    = StAluWb;
      end
      StBeq: begin
        alu_src_a  = SrcARs1;
        alu_src_b  = SrcBRs2;
        alu_op     = AluOpSub;
        result_src = ResAluOut;
        pc_write_c = zero;
        state_d    = StFetch;
      end
      StTrap:  state_d = StTrap;
      default: state_d = StFetch;
    endcase
  end

  // Counter only tracks consecutive stall cycles within one visit to a wait state.
  always_comb begin
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (wait_st && !mem_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StFetch;
      cnt_q        <= '0;
      trap_q       <= 1'b0;
      trap_cause_q <= TrapIllegal;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_d == StTrap && state_q != StTrap) begin
        trap_q       <= 1'b1;
        trap_cause_q <= cause_c;
      end
    end
  end

  alu_op_decoder u_alu_op_decoder (
    .alu_op_i   (alu_op),
    .op5_i      (op[5]),
    .funct3_i   (funct3),
    .funct7b5_i (funct7b5),
    .alu_ctrl_o (alu_ctrl_w)
  );

  // Enables are gated by rst_n so a reset kills any pulse in the same cycle.
  assign mem_req    = mem_req_c & rst_n;
  assign mem_write  = mem_write_c & rst_n;
  assign ir_write   = ir_write_c & rst_n;
  assign pc_write   = pc_write_c & rst_n;
  assign reg_write  = reg_write_c & rst_n;
  assign alu_ctrl   = alu_ctrl_w;
  assign imm_src    = imm_src_of(op);
  assign trap       = trap_q;
  assign trap_cause = trap_cause_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class cycle by
// cycle and compares the full control word against hand-derived values.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
  logic [2:0] alu_ctrl;
  logic       trap, trap_cause;

  int errors = 0;
  int checks = 0;

  multicycle_control #(.TIMEOUT_CYCLES(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .imm_src    (imm_src),
    .alu_ctrl   (alu_ctrl),
    .trap       (trap),
    .trap_cause (trap_cause)
  );

  always #5 clk = ~clk;

  logic [14:0] obs_sig;
  assign obs_sig = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                    alu_src_a, alu_src_b, result_src, alu_ctrl};

  function automatic logic [14:0] sig(input logic mr, input logic mw, input logic adr,
                                      input logic ir, input logic pc, input logic rw,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] res, input logic [2:0] alu);
    return {mr, mw, adr, ir, pc, rw, a, b, res, alu};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Entered at posedge+1; checks mid-cycle, then advances to the next posedge+1.
  task automatic cyc_chk(input string tag, input logic [14:0] exp);
    #3;
    chk(tag, 32'(obs_sig), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op       = o;
    funct3   = f3;
    funct7b5 = f7;
  endtask

  // FETCH/DECODE/EXEC/ALUWB walk for R- and I-type ops.
  task automatic run_alu(input string tag, input logic [6:0] o, input logic [2:0] f3,
                         input logic f7, input logic [14:0] exec_exp);
    set_instr(o, f3, f7);
    mem_ready = 1'b1;
    cyc_chk({tag, "_fetch"},  sig(1, 0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b10, 3'b000));
    cyc_chk({tag, "_decode"}, sig(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b000));
    cyc_chk({tag, "_exec"},   exec_exp);
    cyc_chk({tag, "_aluwb"},  sig(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000));
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    zero      = 1'b1;
    set_instr(7'b0110011, 3'b000, 1'b0);
    @(posedge clk);
    #1;

    // Reset: enables forced low even with mem_ready high, selects at FETCH values.
    #3;
    chk("reset_sig", 32'(obs_sig), 32'(sig(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000)));
    chk("reset_trap", 32'({trap, trap_cause}), 32'(2'b00));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // R-type add, sub, and; I-type ori and addi with instr[30] set.
    run_alu("add", 7'b0110011, 3'b000, 1'b0, sig(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b000));
    run_alu("sub", 7'b0110011, 3'b000, 1'b1, sig(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b001));
    run_alu("and", 7'b0110011, 3'b111, 1'b0, sig(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b010));
    run_alu("ori", 7'b0010011, 3'b110, 1'b0, sig(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b011));
    run_alu("addi", 7'b0010011, 3'b000, 1'b1, sig(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000));
    run_alu("slti", 7'b0010011, 3'b010, 1'b0, sig(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b101));

    // lw with three stall cycles in MEMREAD: 8 cycles total.
    set_instr(7'b0000011, 3'b010, 1'b0);
    mem_ready = 1'b1;
    #1;
    chk("lw_imm", 32'(imm_src), 32'(2'b00));
    cyc_chk("lw_fetch",  sig(1, 0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b10, 3'b000));
    cyc_chk("lw_decode", sig(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b000));
    cyc_chk("lw_memadr", sig(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000));
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc_chk("lw_memread_stall", sig(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000));
    end
    mem_ready = 1'b1;
    cyc_chk("lw_memread_done", sig(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000));
    cyc_chk("lw_memwb",        sig(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 3'b000));
    cyc_chk("lw_next_fetch",   sig(1, 0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b10, 3'b000));

    // beq taken (zero=1) then not taken (zero=0); FETCH already consumed above.
    set_instr(7'b1100011, 3'b000, 1'b0);
    zero = 1'b1;
    #1;
    chk("beq_imm", 32'(imm_src), 32'(2'b10));
    cyc_chk("beq1_decode", sig(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b000));
    cyc_chk("beq1_taken",  sig(0, 0, 0, 0, 1, 0, 2'b10, 2'b00, 2'b00, 3'b001));
    zero = 1'b0;
    cyc_chk("beq2_fetch",  sig(1, 0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b10, 3'b000));
    cyc_chk("beq2_decode", sig(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b000));
    cyc_chk("beq2_nottkn", sig(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b001));

    // jal
    set_instr(7'b1101111, 3'b000, 1'b0);
    #1;
    chk("jal_imm", 32'(imm_src), 32'(2'b11));
    cyc_chk("jal_fetch",  sig(1, 0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b10, 3'b000));
    cyc_chk("jal_decode", sig(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b000));
    cyc_chk("jal_jal",    sig(0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, 3'b000));
    cyc_chk("jal_aluwb",  sig(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000));

    // Illegal opcode: TRAP after DECODE, then 20 cycles with no enables.
    set_instr(7'b1111111, 3'b000, 1'b0);
    zero = 1'b1;
    cyc_chk("ill_fetch",  sig(1, 0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b10, 3'b000));
    cyc_chk("ill_decode", sig(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b000));
    chk("ill_trap", 32'({trap, trap_cause}), 32'(2'b10));
    for (int i = 0; i < 20; i++) begin
      cyc_chk("ill_trap_idle", sig(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000));
    end
    chk("ill_trap_sticky", 32'({trap, trap_cause}), 32'(2'b10));

    // FETCH watchdog: 15 counted stall cycles, trap decided on the next stalled cycle.
    do_reset();
    chk("wd_reset_trap", 32'({trap, trap_cause}), 32'(2'b00));
    set_instr(7'b0110011, 3'b000, 1'b0);
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cyc_chk("wd_fetch_stall", sig(1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000));
      if (i == 14) chk("wd_no_trap_yet", 32'(trap), 32'(1'b0));
    end
    chk("wd_trap", 32'({trap, trap_cause}), 32'(2'b11));
    mem_ready = 1'b1;
    cyc_chk("wd_trap_idle", sig(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000));

    // Same stall but memory completes on the deciding cycle: no trap.
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      cyc_chk("wd2_fetch_stall", sig(1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000));
    end
    mem_ready = 1'b1;
    cyc_chk("wd2_fetch_done", sig(1, 0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b10, 3'b000));
    cyc_chk("wd2_decode",     sig(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b000));
    chk("wd2_no_trap", 32'({trap, trap_cause}), 32'(2'b00));

    // sw, with reset asserted mid-cycle during MEMWRITE.
    cyc_chk("sw_pre_exec",  sig(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b000));
    cyc_chk("sw_pre_aluwb", sig(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000));
    set_instr(7'b0100011, 3'b010, 1'b0);
    #1;
    chk("sw_imm", 32'(imm_src), 32'(2'b01));
    cyc_chk("sw_fetch",  sig(1, 0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b10, 3'b000));
    cyc_chk("sw_decode", sig(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b000));
    cyc_chk("sw_memadr", sig(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000));
    #3;
    chk("sw_memwrite", 32'(obs_sig), 32'(sig(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000)));
    rst_n = 1'b0;
    #1;
    chk("sw_rst_sig", 32'(obs_sig), 32'(sig(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000)));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("sw_rst_trap", 32'({trap, trap_cause}), 32'(2'b00));
    cyc_chk("sw_restart_fetch", sig(1, 0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b10, 3'b000));
    cyc_chk("sw_restart_decode", sig(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
